// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the RX and TX paths.
//   UART_DATA_BITS      : payload bits per frame (8N1)
//   UART_DEFAULT_T_RATE : clk cycles per bit, 50 MHz / 9600 baud
//   uart_state_e        : receiver FSM state encoding
package uart_pkg;

    localparam int UART_DATA_BITS      = 8;
    localparam int UART_DEFAULT_T_RATE = 5208;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side output bundle of the UART receiver.
//   data      : last correctly framed byte
//   done      : one-cycle strobe when data is updated
//   frame_err : one-cycle strobe when the stop bit reads low
//   busy      : receiver is inside a frame (or waiting out a break)
// master = receiver, slave = byte consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      done;
    logic                      frame_err;
    logic                      busy;

    modport master (output data, output done, output frame_err, output busy);
    modport slave  (input  data, input  done, input  frame_err, input  busy);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk    : destination clock
//   Rst_tx : async active-low reset, both flops load RST_VAL
//   d      : asynchronous input
//   q      : synchronized output (two clk edges of latency)
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic Rst_tx,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge Rst_tx) begin
        if (!Rst_tx) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing-error detection.
//   t_rate   : clk cycles per bit (4..8191)
//   clk      : system clock
//   Rst_tx   : async active-low reset
//   Rs232_rx : serial line, idle high, asynchronous to clk
//   rx_if    : data / done / frame_err / busy (master side)
//
// state | meaning
// IDLE  | line idle, waiting for a low on rx_s
// START | counting half a bit, then confirming the start bit is still low
// DATA  | sampling 8 data bits LSB first, one per t_rate cycles
// STOP  | one more bit period, then checking the stop bit
// BREAK | stop bit was low; wait for the line to go high before re-arming
module uart_rx
    import uart_pkg::*;
#(
    parameter int t_rate = UART_DEFAULT_T_RATE
) (
    input  logic      clk,
    input  logic      Rst_tx,
    input  logic      Rs232_rx,
    uart_rx_if.master rx_if
);

    localparam int CW = $clog2(t_rate);
    localparam int H  = t_rate / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(t_rate - 1);

    uart_state_e               state_q, state_d;
    logic [CW-1:0]             baud_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      done_q, err_q;
    logic                      done_d, err_d, sample_bit;
    logic                      rx_s;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk    (clk),
        .Rst_tx (Rst_tx),
        .d      (Rs232_rx),
        .q      (rx_s)
    );

    always_comb begin
        state_d    = state_q;
        sample_bit = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                // a start edge that is gone by mid-bit is treated as noise
                if (baud_cnt == HALF_LAST) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    if (rx_s) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Rst_tx) begin
        if (!Rst_tx) begin
            state_q  <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;

            // counter restarts on every state change and after each data sample
            if (state_d != state_q || sample_bit || state_q == IDLE || state_q == BREAK)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state_q == START && state_d == DATA)
                bit_idx <= '0;
            else if (sample_bit)
                bit_idx <= bit_idx + 3'd1;

            if (sample_bit) shreg[bit_idx] <= rx_s;
            if (done_d)     data_q         <= shreg;
        end
    end

    assign rx_if.data      = data_q;
    assign rx_if.done      = done_q;
    assign rx_if.frame_err = err_q;
    assign rx_if.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int T = 16;
    localparam int H = T / 2;

    typedef struct {
        bit         is_err;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic Rst_tx = 1'b0;
    logic Rs232_rx = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t sb[$];
    logic [7:0] last_good = 8'h00;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    bit prev_done = 1'b0;
    bit prev_err = 1'b0;
    exp_t mon_e;

    uart_rx_if u_if ();

    uart_rx #(.t_rate(T)) dut (
        .clk      (clk),
        .Rst_tx   (Rst_tx),
        .Rs232_rx (Rs232_rx),
        .rx_if    (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Line level seen at posedge index t after the start edge, for a frame
    // with bit period p followed by the constant level 'after'.
    function automatic bit line_at(input logic [7:0] b, input bit stop, input int p,
                                   input bit after, input int t);
        if (t < p)      return 1'b0;
        if (t < 9 * p)  return b[t / p - 1];
        if (t < 10 * p) return stop;
        return after;
    endfunction

    task automatic drive_line(input bit v, input int n);
        Rs232_rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Expected outcome comes from reading the generated waveform at the
    // receiver's sample instants (2-cycle synchronizer, then H + k*T), so
    // off-rate frames predict whatever the mid-bit sampler actually picks up.
    // Must be called at a negedge.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int p,
                              input bit after);
        exp_t e;
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = line_at(b, stop, p, after, H + (i + 1) * T);
        e.is_err = !line_at(b, stop, p, after, H + 9 * T);
        e.val    = v;
        e.cyc    = cyc + 3 + H + 9 * T;
        sb.push_back(e);
        drive_line(1'b0, p);
        for (int i = 0; i < 8; i++) drive_line(b[i], p);
        drive_line(stop, p);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // Scoreboard monitor: every done/frame_err must match the head of the queue.
    always @(negedge clk) begin
        if (Rst_tx) begin
            if (u_if.done || u_if.frame_err) begin
                check("exclusive", int'(u_if.done & u_if.frame_err), 0);
                check("pulse_width", int'((u_if.done & prev_done) | (u_if.frame_err & prev_err)), 0);
                check("expected_event", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("event_kind", int'(u_if.frame_err), int'(mon_e.is_err));
                    check("event_cycle", cyc, mon_e.cyc);
                    if (u_if.done) begin
                        check("data", int'(u_if.data), int'(mon_e.val));
                        check("busy_at_done", int'(u_if.busy), 0);
                        last_good     = mon_e.val;
                        prev_done_cyc = last_done_cyc;
                        last_done_cyc = cyc;
                    end else begin
                        check("data_held", int'(u_if.data), int'(last_good));
                    end
                end
            end
            prev_done = u_if.done;
            prev_err  = u_if.frame_err;
        end else begin
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end
    end

    initial begin
        int busy_cnt;
        logic [7:0] rb;
        bit rs;
        int gap;

        repeat (4) @(negedge clk);
        Rst_tx = 1'b1;
        @(negedge clk);
        check("rst_data", int'(u_if.data), 0);
        check("rst_done", int'(u_if.done), 0);
        check("rst_ferr", int'(u_if.frame_err), 0);
        check("rst_busy", int'(u_if.busy), 0);
        repeat (5) @(negedge clk);

        // good frame
        send_frame(8'hA5, 1'b1, T, 1'b1);
        drive_line(1'b1, 10);
        drain("drain_a5", 200);
        check("a5_data", int'(u_if.data), 8'hA5);

        // short low glitch
        busy_cnt = 0;
        for (int i = 0; i < 34; i++) begin
            Rs232_rx = (i < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (u_if.busy) busy_cnt++;
        end
        check("glitch_busy_cycles", busy_cnt, 8);
        check("glitch_data", int'(u_if.data), 8'hA5);

        // framing error, line held low afterwards
        send_frame(8'h3C, 1'b0, T, 1'b0);
        drive_line(1'b0, 40);
        check("break_busy", int'(u_if.busy), 1);
        drive_line(1'b1, 5);
        check("break_exit_busy", int'(u_if.busy), 0);
        drive_line(1'b1, 40);
        drain("drain_3c", 10);
        check("ferr_data", int'(u_if.data), 8'hA5);

        // back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, T, 1'b0);
        send_frame(8'hFF, 1'b1, T, 1'b1);
        drive_line(1'b1, 10);
        drain("drain_b2b", 200);
        check("b2b_spacing", last_done_cyc - prev_done_cyc, 160);
        check("b2b_data", int'(u_if.data), 8'hFF);

        // reset during data bit 4 of 0x81
        Rs232_rx = 1'b0;
        repeat (T) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_line(i == 0 ? 1'b1 : 1'b0, T);
        drive_line(1'b0, 8);
        Rst_tx = 1'b0;
        #1;
        check("midrst_data", int'(u_if.data), 0);
        check("midrst_done", int'(u_if.done), 0);
        check("midrst_ferr", int'(u_if.frame_err), 0);
        check("midrst_busy", int'(u_if.busy), 0);
        last_good = 8'h00;
        Rs232_rx  = 1'b1;
        repeat (3) @(negedge clk);
        Rst_tx = 1'b1;
        drive_line(1'b1, 200);
        check("midrst_no_event", sb.size(), 0);
        send_frame(8'h81, 1'b1, T, 1'b1);
        drive_line(1'b1, 10);
        drain("drain_81", 200);
        check("post_rst_data", int'(u_if.data), 8'h81);

        // off-rate transmitters
        send_frame(8'h55, 1'b1, 15, 1'b1);
        drive_line(1'b1, 20);
        drain("drain_r15", 200);
        send_frame(8'h55, 1'b1, 17, 1'b1);
        drive_line(1'b1, 20);
        drain("drain_r17", 200);

        // random traffic
        for (int k = 0; k < 12; k++) begin
            rb  = 8'($urandom_range(0, 255));
            rs  = ($urandom_range(0, 3) != 0);
            gap = rs ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
            send_frame(rb, rs, T, gap != 0);
            if (gap != 0) drive_line(1'b1, gap);
        end
        drive_line(1'b1, 10);
        drain("drain_random", 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
